// File: rtl/data_path_scan_mux_if.sv
// data_path_scan_mux_if: select/source inputs and registered outputs of the scan mux
interface data_path_scan_mux_if #(
  parameter int WIDTH = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W = $clog2(CHANNELS)
);
  logic mode;
  logic [SEL_W-1:0] sel;
  logic [CHANNELS-1:0] en_mask;
  logic hold;
  logic [CHANNELS*WIDTH-1:0] din;
  logic [WIDTH-1:0] data_path;
  logic [SEL_W-1:0] cur_ch;
  logic changed;
  modport master(output mode, sel, en_mask, hold, din, input data_path, cur_ch, changed);
  modport slave(input mode, sel, en_mask, hold, din, output data_path, cur_ch, changed);
endinterface

// File: rtl/data_path_scan_mux.sv
// data_path_scan_mux: registered channel selector with manual select or round-robin dwell scan
module data_path_scan_mux #(
  parameter int WIDTH = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W = $clog2(CHANNELS),
  parameter int DWELL = 8
) (
  input logic clk,
  input logic rst,
  data_path_scan_mux_if.slave b
);
  localparam int CNT_W = DWELL > 1 ? $clog2(DWELL) : 1;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] cur, up, lo, nc;
  logic up_ok, lo_ok, wrap, chg;
  logic [WIDTH-1:0] dp, nd;
  assign wrap = cnt == CNT_W'(DWELL - 1);
  // Downward scan leaves the lowest enabled index overall and the lowest one above cur.
  always_comb begin
    up = '0;
    up_ok = 1'b0;
    lo = '0;
    lo_ok = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--)
      if (b.en_mask[i]) begin
        lo = SEL_W'(i);
        lo_ok = 1'b1;
        if (i > int'(cur)) begin
          up = SEL_W'(i);
          up_ok = 1'b1;
        end
      end
    nc = !b.mode ? b.sel : (wrap && lo_ok) ? (up_ok ? up : lo) : cur;
    nd = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (nc == SEL_W'(i) && (!b.mode || lo_ok)) nd = b.din[i*WIDTH +: WIDTH];
  end
  always_ff @(posedge clk)
    if (rst) begin
      dp <= '0;
      cur <= '0;
      chg <= 1'b0;
      cnt <= '0;
    end else if (b.hold) begin
      chg <= 1'b0;
    end else begin
      dp <= nd;
      cur <= nc;
      chg <= nc != cur;
      cnt <= (!b.mode || wrap) ? '0 : cnt + 1'b1;
    end
  assign b.data_path = dp;
  assign b.cur_ch = cur;
  assign b.changed = chg;
endmodule

// File: tb/tb_data_path_scan_mux.sv
// tb_data_path_scan_mux: table-driven scoreboard bench for a 4-channel and a 3-channel instance
module tb_data_path_scan_mux;
  typedef struct {
    logic rst;
    logic mode;
    logic [1:0] sel;
    logic [3:0] mask;
    logic hold;
    logic [15:0] din;
    logic [3:0] dp;
    logic [1:0] ch;
    logic chg;
  } vec_t;
  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  vec_t sb[$];
  vec_t tab[$];
  data_path_scan_mux_if #(.WIDTH(4), .CHANNELS(4)) a ();
  data_path_scan_mux_if #(.WIDTH(4), .CHANNELS(3)) c ();
  data_path_scan_mux #(.WIDTH(4), .CHANNELS(4), .DWELL(2)) dut4 (.clk(clk), .rst(rst0), .b(a.slave));
  data_path_scan_mux #(.WIDTH(4), .CHANNELS(3), .DWELL(1)) dut3 (.clk(clk), .rst(rst1), .b(c.slave));
  always #5 clk = ~clk;
  function automatic vec_t v(logic r, logic m, logic [1:0] s, logic [3:0] k, logic h, logic [15:0] d,
                             logic [3:0] edp, logic [1:0] ech, logic ec);
    vec_t t;
    t.rst = r; t.mode = m; t.sel = s; t.mask = k; t.hold = h; t.din = d;
    t.dp = edp; t.ch = ech; t.chg = ec;
    return t;
  endfunction
  task automatic chk(input string nm, input int k, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, k, got, exp);
    end
  endtask
  task automatic apply(input int w, input vec_t t, input int k);
    vec_t e;
    sb.push_back(t);
    if (w == 0) begin
      rst0 = t.rst; a.mode = t.mode; a.sel = t.sel; a.en_mask = t.mask; a.hold = t.hold; a.din = t.din;
    end else begin
      rst1 = t.rst; c.mode = t.mode; c.sel = t.sel; c.en_mask = t.mask[2:0]; c.hold = t.hold; c.din = t.din[11:0];
    end
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (w == 0) begin
      chk("dp4", k, a.data_path, e.dp);
      chk("ch4", k, {2'b0, a.cur_ch}, {2'b0, e.ch});
      chk("chg4", k, {3'b0, a.changed}, {3'b0, e.chg});
    end else begin
      chk("dp3", k, c.data_path, e.dp);
      chk("ch3", k, {2'b0, c.cur_ch}, {2'b0, e.ch});
      chk("chg3", k, {3'b0, c.changed}, {3'b0, e.chg});
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end
  initial begin
    c.mode = 1'b0; c.sel = '0; c.en_mask = '0; c.hold = 1'b0; c.din = '0;
    // channel 0 = A, 1 = B, 2 = C, 3 = D
    tab.push_back(v(1, 0, 2, 4'b0000, 0, 16'hDCBA, 4'h0, 0, 0));
    tab.push_back(v(1, 0, 2, 4'b0000, 0, 16'hDCBA, 4'h0, 0, 0));
    tab.push_back(v(0, 0, 2, 4'b0000, 0, 16'hDCBA, 4'hC, 2, 1));
    tab.push_back(v(0, 0, 2, 4'b0000, 0, 16'hDCBA, 4'hC, 2, 0));
    tab.push_back(v(0, 0, 2, 4'b0000, 0, 16'hD7BA, 4'h7, 2, 0));
    tab.push_back(v(0, 0, 0, 4'b0000, 0, 16'hDCBA, 4'hA, 0, 1));
    tab.push_back(v(0, 1, 0, 4'b1011, 0, 16'hDCBA, 4'hA, 0, 0));
    tab.push_back(v(0, 1, 0, 4'b1011, 0, 16'hDCBA, 4'hB, 1, 1));
    tab.push_back(v(0, 1, 0, 4'b1011, 0, 16'hDCBA, 4'hB, 1, 0));
    tab.push_back(v(0, 1, 0, 4'b1011, 0, 16'hDCBA, 4'hD, 3, 1));
    tab.push_back(v(0, 1, 0, 4'b1011, 0, 16'hDCBA, 4'hD, 3, 0));
    tab.push_back(v(0, 1, 0, 4'b1011, 0, 16'hDCBA, 4'hA, 0, 1));
    tab.push_back(v(0, 1, 0, 4'b1011, 0, 16'hDCBA, 4'hA, 0, 0));
    tab.push_back(v(0, 1, 0, 4'b0000, 0, 16'hDCBA, 4'h0, 0, 0));
    tab.push_back(v(0, 1, 0, 4'b0100, 0, 16'hDCBA, 4'hA, 0, 0));
    tab.push_back(v(0, 1, 0, 4'b0100, 0, 16'hDCBA, 4'hC, 2, 1));
    tab.push_back(v(0, 1, 0, 4'b1011, 0, 16'hDCBA, 4'hC, 2, 0));
    tab.push_back(v(0, 1, 0, 4'b1011, 1, 16'hDCBA, 4'hC, 2, 0));
    tab.push_back(v(0, 1, 0, 4'b1011, 1, 16'hD7BA, 4'hC, 2, 0));
    tab.push_back(v(0, 1, 0, 4'b1011, 1, 16'hDCBA, 4'hC, 2, 0));
    tab.push_back(v(0, 1, 0, 4'b1011, 0, 16'hDCBA, 4'hD, 3, 1));
    tab.push_back(v(0, 1, 0, 4'b1011, 0, 16'hDCBA, 4'hD, 3, 0));
    tab.push_back(v(1, 1, 0, 4'b1011, 0, 16'hDCBA, 4'h0, 0, 0));
    tab.push_back(v(0, 1, 0, 4'b1011, 0, 16'hDCBA, 4'hA, 0, 0));
    tab.push_back(v(0, 1, 0, 4'b1011, 0, 16'hDCBA, 4'hB, 1, 1));
    tab.push_back(v(0, 0, 3, 4'b1011, 0, 16'hDCBA, 4'hD, 3, 1));
    tab.push_back(v(0, 1, 3, 4'b1011, 0, 16'hDCBA, 4'hD, 3, 0));
    tab.push_back(v(0, 1, 3, 4'b1011, 0, 16'hDCBA, 4'hA, 0, 1));
    tab.push_back(v(0, 1, 3, 4'b1011, 1, 16'hDCBA, 4'hA, 0, 0));
    tab.push_back(v(0, 0, 0, 4'b1011, 0, 16'hDCBA, 4'hA, 0, 0));
    tab.push_back(v(1, 0, 1, 4'b1011, 1, 16'hDCBA, 4'h0, 0, 0));
    tab.push_back(v(0, 0, 1, 4'b1011, 0, 16'hDCBA, 4'hB, 1, 1));
    foreach (tab[i]) apply(0, tab[i], i);
    // three-channel instance, one-cycle dwell, out-of-range select
    apply(1, v(1, 0, 3, 4'b0000, 0, 16'h0CBA, 4'h0, 0, 0), 0);
    apply(1, v(0, 0, 3, 4'b0000, 0, 16'h0CBA, 4'h0, 3, 1), 1);
    apply(1, v(0, 0, 1, 4'b0000, 0, 16'h0CBA, 4'hB, 1, 1), 2);
    apply(1, v(0, 0, 1, 4'b0000, 0, 16'h0CBA, 4'hB, 1, 0), 3);
    apply(1, v(0, 1, 1, 4'b0111, 0, 16'h0CBA, 4'hC, 2, 1), 4);
    apply(1, v(0, 1, 1, 4'b0111, 0, 16'h0CBA, 4'hA, 0, 1), 5);
    apply(1, v(0, 1, 1, 4'b0111, 0, 16'h0CBA, 4'hB, 1, 1), 6);
    apply(1, v(0, 1, 1, 4'b0010, 0, 16'h0CBA, 4'hB, 1, 0), 7);
    apply(1, v(0, 0, 3, 4'b0010, 0, 16'h0CBA, 4'h0, 3, 1), 8);
    apply(1, v(0, 1, 3, 4'b0101, 0, 16'h0CBA, 4'hA, 0, 1), 9);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard: got %0d leftover entries expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
